obf_key_loader: RTL and testbench

- Sequential key-delivery stage directly upstream of the MUX2-camouflaged c432 netlist; drives its key inputs (s_0, s_1, ...).
- Shifts a key frame in serially over a valid/ready handshake and checks parity.
- Presents the key on a stable parallel bus only after a successful check.
- Counts failed loads and enters a sticky lockout after a limit, so the obfuscated core never sees an unchecked or partially loaded key.

---
 rtl/obf_key_loader_pkg.sv | 31 +++
 rtl/obf_key_loader_if.sv | 24 ++
 rtl/obf_key_shift_reg.sv | 41 ++++
 rtl/obf_key_loader.sv | 141 ++++++++++++++
 tb/tb_obf_key_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/obf_key_loader_pkg.sv
// Shared types and helpers for the key loader that feeds the camouflaged core's
// s_* key inputs.
package obf_key_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CHECK   = 3'd2,
    ARMED   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam int DEF_KEY_W    = 2;
  localparam int DEF_MAX_FAIL = 3;
  localparam int DEF_FAIL_W   = 2;

  // XOR-reduce the low n bits of a frame; 0 means even parity holds.
  function automatic logic frame_parity(input logic [31:0] frame, input int unsigned n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(n)) begin
        p = p ^ frame[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/obf_key_loader_if.sv
// Serial key handshake plus parallel key bus between a key source and the loader.
interface obf_key_if #(
  parameter int KEY_W = obf_key_pkg::DEF_KEY_W
);
  logic             load_start;
  logic             key_bit_valid;
  logic             key_bit;
  logic             key_bit_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             err;
  logic             lockout;
  logic             busy;

  modport master (
    output load_start, key_bit_valid, key_bit,
    input  key_bit_ready, key_out, key_valid, err, lockout, busy
  );

  modport slave (
    input  load_start, key_bit_valid, key_bit,
    output key_bit_ready, key_out, key_valid, err, lockout, busy
  );
endinterface

// File: rtl/obf_key_shift_reg.sv
// Shadow register for one serial key frame (key bits then parity), with an
// index counter and a done strobe on the edge that captures the parity bit.
module obf_key_shift_reg #(
  parameter int KEY_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           cap,
  input  logic           bit_in,
  output logic [KEY_W:0] frame_s,
  output logic           done_s
);

  localparam int FRAME_W = KEY_W + 1;
  localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  logic [CNT_W-1:0]   cnt_r;
  logic [FRAME_W-1:0] frame_r;

  assign frame_s = frame_r;
  assign done_s  = cap && (cnt_r == CNT_W'(KEY_W));

  // Indexed capture of accepted bits; clear restarts the frame at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      frame_r <= '0;
    end else if (clr) begin
      cnt_r   <= '0;
      frame_r <= '0;
    end else if (cap) begin
      frame_r[cnt_r] <= bit_in;
      cnt_r          <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r   <= cnt_r;
      frame_r <= frame_r;
    end
  end

endmodule

// File: rtl/obf_key_loader.sv
// Key loader: serial frame intake, parity check, guarded key presentation to the
// obfuscated core and a sticky lockout after repeated parity failures.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int MAX_FAIL = DEF_MAX_FAIL,
  parameter int FAIL_W   = DEF_FAIL_W
) (
  input  logic      clk,
  input  logic      rst,
  obf_key_if.slave  bus
);

  localparam int FRAME_W = KEY_W + 1;

  state_t              state_r, state_s;
  logic [FAIL_W-1:0]   fail_cnt_r, fail_cnt_s, fail_inc_s;
  logic [KEY_W-1:0]    key_out_r, key_out_s;
  logic                key_valid_r, key_valid_s;
  logic                err_r, err_s;
  logic                ready_r, ready_s;
  logic                busy_r, busy_s;
  logic                lockout_r, lockout_s;
  logic                clr_s, cap_s, done_s, parity_ok_s;
  logic [KEY_W:0]      frame_s;

  assign cap_s       = bus.key_bit_valid && ready_r && (state_r == SHIFT);
  assign parity_ok_s = ~frame_parity(32'(frame_s), FRAME_W);

  obf_key_shift_reg #(.KEY_W(KEY_W)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .cap     (cap_s),
    .bit_in  (bus.key_bit),
    .frame_s (frame_s),
    .done_s  (done_s)
  );

  // Next-state, fail accounting and next values of every registered output.
  always_comb begin
    state_s     = state_r;
    fail_cnt_s  = fail_cnt_r;
    fail_inc_s  = fail_cnt_r + FAIL_W'(1);
    key_out_s   = key_out_r;
    key_valid_s = key_valid_r;
    err_s       = 1'b0;
    clr_s       = 1'b0;
    case (state_r)
      IDLE: begin
        key_out_s   = '0;
        key_valid_s = 1'b0;
        if (bus.load_start) begin
          state_s = SHIFT;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (done_s) begin
          state_s = CHECK;
        end else begin
          state_s = SHIFT;
        end
      end
      CHECK: begin
        if (parity_ok_s) begin
          state_s     = ARMED;
          key_out_s   = frame_s[KEY_W-1:0];
          key_valid_s = 1'b1;
          fail_cnt_s  = '0;
        end else begin
          err_s      = 1'b1;
          fail_cnt_s = fail_inc_s;
          if (fail_inc_s == FAIL_W'(MAX_FAIL)) begin
            state_s = LOCKOUT;
          end else begin
            state_s = IDLE;
          end
        end
      end
      ARMED: begin
        // Drop the key on the reload edge so the core never runs a stale key.
        if (bus.load_start) begin
          state_s     = SHIFT;
          clr_s       = 1'b1;
          key_out_s   = '0;
          key_valid_s = 1'b0;
        end else begin
          state_s = ARMED;
        end
      end
      LOCKOUT: begin
        state_s     = LOCKOUT;
        key_out_s   = '0;
        key_valid_s = 1'b0;
      end
      default: begin
        state_s     = IDLE;
        key_out_s   = '0;
        key_valid_s = 1'b0;
      end
    endcase
    ready_s   = (state_r == SHIFT) && !done_s;
    busy_s    = (state_s == SHIFT) || (state_s == CHECK);
    lockout_s = (state_s == LOCKOUT);
  end

  // State, fail counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      fail_cnt_r  <= '0;
      key_out_r   <= '0;
      key_valid_r <= 1'b0;
      err_r       <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      lockout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      fail_cnt_r  <= fail_cnt_s;
      key_out_r   <= key_out_s;
      key_valid_r <= key_valid_s;
      err_r       <= err_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      lockout_r   <= lockout_s;
    end
  end

  assign bus.key_out       = key_out_r;
  assign bus.key_valid     = key_valid_r;
  assign bus.err           = err_r;
  assign bus.key_bit_ready = ready_r;
  assign bus.busy          = busy_r;
  assign bus.lockout       = lockout_r;

endmodule

// File: tb/tb_obf_key_loader.sv
// Scoreboard bench for obf_key_loader: a frame-level model predicts each load's
// outcome, and a negedge monitor matches DUT key/err events against it.
module tb_obf_key_loader;

  localparam int KEY_W    = 2;
  localparam int MAX_FAIL = 3;

  typedef struct {
    int               kind;       // 0 = key armed, 1 = parity error
    logic [KEY_W-1:0] key;
    int               lat_start;  // edges from load_start, -1 = unchecked
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  obf_key_if #(.KEY_W(KEY_W)) bus ();

  obf_key_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL), .FAIL_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_cyc = 0;
  int   checks = 0, errors = 0;
  int   mon_checks = 0, mon_errors = 0;
  int   fails_m = 0;
  bit   locked_m = 1'b0;
  bit   armed_m = 1'b0;
  logic kv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every err pulse and key_valid rise must match the next prediction.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b0) begin
      kv_prev = 1'b0;
    end else begin
      if (bus.err === 1'b1 && bus.key_valid === 1'b1) begin
        mon_checks++; mon_errors++;
        $display("FAIL excl got err=1 key_valid=1 required not both high");
      end
      if (bus.err === 1'b1) begin
        mon_checks++;
        if (exp_q.size() == 0) begin
          mon_errors++;
          $display("FAIL err_unexpected got err pulse required no event");
        end else begin
          e = exp_q.pop_front();
          if (e.kind != 1) begin
            mon_errors++;
            $display("FAIL err_kind got err pulse required key %b", e.key);
          end
        end
      end
      if (bus.key_valid === 1'b1 && kv_prev !== 1'b1) begin
        mon_checks++;
        if (exp_q.size() == 0) begin
          mon_errors++;
          $display("FAIL kv_unexpected got key_valid key=%b required no event", bus.key_out);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != 0) begin
            mon_errors++;
            $display("FAIL kv_kind got key_valid key=%b required err pulse", bus.key_out);
          end else begin
            if (bus.key_out !== e.key) begin
              mon_errors++;
              $display("FAIL key_out got %b required %b", bus.key_out, e.key);
            end
            mon_checks++;
            if (cyc - last_cyc != 1) begin
              mon_errors++;
              $display("FAIL lat_last got %0d required 1", cyc - last_cyc);
            end
            if (e.lat_start >= 0) begin
              mon_checks++;
              if (cyc - start_cyc != e.lat_start) begin
                mon_errors++;
                $display("FAIL lat_start got %0d required %0d", cyc - start_cyc, e.lat_start);
              end
            end
          end
        end
      end
      kv_prev = bus.key_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_key_out", 32'(bus.key_out), 32'd0);
    chk("rst_key_valid", 32'(bus.key_valid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_lockout", 32'(bus.lockout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.key_bit_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    fails_m  = 0;
    locked_m = 1'b0;
    armed_m  = 1'b0;
  endtask

  // One complete load: fr[0] first, parity fr[KEY_W] last, gap idle cycles per bit.
  task automatic send_frame(input logic [KEY_W:0] fr, input int gap);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    start_cyc = cyc;
    if (armed_m && !locked_m) begin
      chk("reload_kv", 32'(bus.key_valid), 32'd0);
      chk("reload_key", 32'(bus.key_out), 32'd0);
    end
    if (locked_m) begin
      for (int i = 0; i <= KEY_W; i++) begin
        bus.key_bit_valid = 1'b1;
        bus.key_bit       = fr[i];
        @(negedge clk);
      end
      bus.key_bit_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("locked_flag", 32'(bus.lockout), 32'd1);
      chk("locked_key", 32'(bus.key_out), 32'd0);
      chk("locked_kv", 32'(bus.key_valid), 32'd0);
      chk("locked_ready", 32'(bus.key_bit_ready), 32'd0);
      return;
    end
    if ((^fr) == 1'b0) begin
      e.kind = 0; e.key = fr[KEY_W-1:0]; e.lat_start = (gap == 0) ? KEY_W + 3 : -1;
      fails_m = 0;
      armed_m = 1'b1;
    end else begin
      e.kind = 1; e.key = '0; e.lat_start = -1;
      fails_m++;
      armed_m = 1'b0;
      if (fails_m >= MAX_FAIL) locked_m = 1'b1;
    end
    exp_q.push_back(e);
    for (int i = 0; i <= KEY_W; i++) begin
      bus.key_bit_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.key_bit_valid = 1'b1;
      bus.key_bit       = fr[i];
      n = 0;
      while (bus.key_bit_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL ready_timeout got ready=0 for 20 cycles required ready=1");
      end
      @(negedge clk);
    end
    last_cyc = cyc;
    bus.key_bit_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("lockout", 32'(bus.lockout), 32'(locked_m));
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("kv_level", 32'(bus.key_valid), 32'(armed_m));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [KEY_W:0] fr;
    int             gap;
    rst = 1'b1;
    bus.load_start    = 1'b0;
    bus.key_bit_valid = 1'b0;
    bus.key_bit       = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    send_frame(3'b101, 0);               // bits 1,0,1 -> key 01 at edge 5
    send_frame(3'b110, 2);               // bits 0,1,1 with gaps -> key 10
    for (int i = 0; i < MAX_FAIL; i++) send_frame(3'b111, 0);
    send_frame(3'b101, 0);               // ignored under lockout
    do_reset();

    send_frame(3'b101, 0);
    send_frame(3'b011, 0);               // bits 1,1,0 -> key 11
    send_frame(3'b111, 0);
    send_frame(3'b111, 1);
    send_frame(3'b101, 0);               // clears the fail streak
    send_frame(3'b111, 0);               // single failure, no lockout

    // Abandon a frame after two accepted bits.
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start    = 1'b0;
    bus.key_bit_valid = 1'b1;
    bus.key_bit       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      while (bus.key_bit_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    bus.key_bit_valid = 1'b0;
    do_reset();
    send_frame(3'b000, 0);

    for (int t = 0; t < 40; t++) begin
      fr  = KEY_W'(0) + ($urandom_range(0, 7));
      gap = $urandom_range(0, 2);
      if (locked_m && ($urandom_range(0, 1) == 1)) do_reset();
      send_frame(fr, gap);
    end

    repeat (3) @(negedge clk);
    checks = checks + mon_checks;
    errors = errors + mon_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
